// File: rtl/fifox3x16_feeder_if.sv
// Feature-buffer read port and line-buffer write port of the 16-channel window feeder.
interface fifox3x16_feeder_if #(
    parameter int bitsize = 14,
    parameter int ADDR_W  = 16
);
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [16*bitsize-1:0] mem_rd_data;
    logic [16*bitsize-1:0] pixels_out;
    logic                  wr_en;
    logic                  zero_buffering;
    logic                  ex_window_done;
    logic                  depth_window_done;

    modport master (
        output mem_rd_en, mem_addr, pixels_out, wr_en, zero_buffering, ex_window_done,
        input  mem_rd_data, depth_window_done
    );

    modport slave (
        input  mem_rd_en, mem_addr, pixels_out, wr_en, zero_buffering, ex_window_done,
        output mem_rd_data, depth_window_done
    );
endinterface

// File: rtl/fifox3x16_feeder.sv
// Streams each 16-channel depth group as a zero-padded W x W raster into the line buffer,
// one position per cycle, then waits for the line buffer's depth-window handshake.
module fifox3x16_feeder #(
    parameter int bitsize = 14,
    parameter int PAD     = 1,
    parameter int ADDR_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [6:0]           row_size,
    input  logic [5:0]           num_groups,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 busy,
    output logic                 done,
    fifox3x16_feeder_if.master   bus
);
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_END, S_WAIT, S_DONE} state_t;

    state_t            state, state_d;
    logic [6:0]        row_q;
    logic [5:0]        groups_q;
    logic [5:0]        group_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [8:0]        r_q, c_q;
    logic              win_seen;
    logic              wr_q, pad_q;

    logic [8:0]        wdim, pad_lo, pad_hi;
    logic              is_pad, last_pos, last_group, win_ack;
    logic              rd_en, ex_done;

    assign wdim       = {2'b00, row_q} + 9'(2*PAD);
    assign pad_lo     = 9'(PAD);
    assign pad_hi     = {2'b00, row_q} + 9'(PAD);
    assign is_pad     = (r_q < pad_lo) || (r_q >= pad_hi) || (c_q < pad_lo) || (c_q >= pad_hi);
    assign last_pos   = (r_q == wdim - 9'd1) && (c_q == wdim - 9'd1);
    assign last_group = (group_q == groups_q - 6'd1);
    assign win_ack    = win_seen || bus.depth_window_done;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        ex_done = 1'b0;
        rd_en   = 1'b0;
        case (state)
            S_IDLE:   if (start) state_d = (num_groups == 6'd0) ? S_DONE : S_STREAM;
            S_STREAM: begin
                busy  = 1'b1;
                rd_en = !is_pad;
                if (last_pos) state_d = S_FLUSH;
            end
            S_FLUSH:  begin
                busy    = 1'b1;
                state_d = S_END;
            end
            S_END:    begin
                busy    = 1'b1;
                ex_done = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT:   begin
                busy = 1'b1;
                if (win_ack) state_d = last_group ? S_DONE : S_STREAM;
            end
            S_DONE:   begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            row_q    <= '0;
            groups_q <= '0;
            group_q  <= '0;
            addr_cnt <= '0;
            r_q      <= '0;
            c_q      <= '0;
            win_seen <= 1'b0;
            wr_q     <= 1'b0;
            pad_q    <= 1'b0;
        end else begin
            state <= state_d;

            if (state == S_IDLE && start) begin
                row_q    <= row_size;
                groups_q <= num_groups;
                addr_cnt <= base_addr;
                group_q  <= '0;
            end

            // Raster position restarts at (0,0) whenever a group begins streaming.
            if (state == S_STREAM) begin
                if (!is_pad) addr_cnt <= addr_cnt + 1'b1;
                if (c_q == wdim - 9'd1) begin
                    c_q <= '0;
                    r_q <= r_q + 9'd1;
                end else begin
                    c_q <= c_q + 9'd1;
                end
            end else begin
                r_q <= '0;
                c_q <= '0;
            end

            if (state == S_WAIT && win_ack && !last_group) group_q <= group_q + 6'd1;

            if (state == S_WAIT && win_ack)
                win_seen <= 1'b0;
            else if ((state == S_FLUSH || state == S_END || state == S_WAIT) && bus.depth_window_done)
                win_seen <= 1'b1;

            wr_q  <= (state == S_STREAM);
            pad_q <= (state == S_STREAM) && is_pad;
        end
    end

    // Read data lands one cycle after issue, aligned with the registered write strobe.
    assign bus.mem_rd_en      = rd_en;
    assign bus.mem_addr       = rd_en ? addr_cnt : '0;
    assign bus.wr_en          = wr_q;
    assign bus.zero_buffering = pad_q;
    assign bus.pixels_out     = (wr_q && !pad_q) ? bus.mem_rd_data : '0;
    assign bus.ex_window_done = ex_done;
endmodule

// File: doc/fifox3x16_feeder.md
Name: fifox3x16_feeder

Overview:
Producer side of the 16-channel window line-buffer. Reads one 16-channel pixel word per cycle from the feature-map buffer in raster order. Wraps each depth group's row_size x row_size tile in PAD rings of zeros and drives the line-buffer write port: pixels, wr_en, zero-buffering flag and end-of-window pulse. Handshakes on the line-buffer's depth-window-done before it streams the next depth group of 16 channels.

Parameters:
bitsize, 14, width of one channel sample
PAD, 1, zero rings added on each side (legal values 1 or 2)
ADDR_W, 16, feature-buffer word address width

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; ignored unless idle
row_size  in  7  unpadded tile width = height
num_groups  in  6  number of 16-channel depth groups
base_addr  in  ADDR_W  word address of first pixel of group 0
mem_rd_en  out  1  buffer read strobe; data returns exactly one cycle later
mem_addr  out  ADDR_W  buffer read address
mem_rd_data  in  16*bitsize  buffer read data, channel k at [k*bitsize +: bitsize]
pixels_out  out  16*bitsize  line-buffer pixel word
wr_en  out  1  line-buffer write strobe
zero_buffering  out  1  current pixel is padding
ex_window_done  out  1  one-cycle pulse after a group's last pixel
depth_window_done  in  1  line-buffer has emitted the group's final window
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when all groups are finished

Behaviour:
- Reset (rst=0 at an edge): state IDLE. All outputs 0. Counters and the sticky flag cleared. Reset applies from any state; an in-flight read is discarded.
- Latched on start in IDLE: row_size, num_groups, base_addr. Derived W = row_size + 2*PAD, at least 9 bits wide.
- States: IDLE, STREAM, FLUSH, END, WAIT, DONE.
- IDLE -> STREAM on start; if num_groups==0, go to DONE instead.
- Stage 0 (STREAM) issues one position (r,c) per cycle, raster order, r and c each 0..W-1.
- A position is padding when r<PAD, r>=row_size+PAD, c<PAD or c>=row_size+PAD.
- Non-pad position: mem_rd_en=1, mem_addr=addr_cnt, then addr_cnt++ (mod 2^ADDR_W).
- Pad position: mem_rd_en=0.
- addr_cnt loads base_addr on start and is never reset between groups, because groups are contiguous.
- Stage 1, registered, one cycle after issue:
  - wr_en=1
  - zero_buffering = pad flag
  - pixels_out = pad ? 0 : mem_rd_data
- Latency: first wr_en occurs 2 cycles after the start pulse. wr_en is continuous for W*W cycles per group, with no gaps.
- STREAM -> FLUSH after issuing (W-1,W-1). FLUSH writes the last pixel, then goes to END.
- END: ex_window_done=1 for one cycle, wr_en=0, then go to WAIT.
- Sticky flag win_seen: set by depth_window_done in any of FLUSH, END or WAIT; cleared on leaving WAIT.
- WAIT, on win_seen or depth_window_done:
  - if group==num_groups-1: go to DONE
  - else: group++, go to STREAM (next issue the following cycle).
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- busy=1 in STREAM, FLUSH, END and WAIT.
- start in any non-IDLE state is ignored.
- depth_window_done in IDLE, STREAM or DONE is ignored.
- Outside stage-1 activity, wr_en, zero_buffering and pixels_out are 0.
- row_size==0: W=2*PAD, all positions are pad, no memory reads, normal handshake otherwise.

Test Plan:
1. PAD=1, row_size=2, num_groups=1, base=0x0010:
   - 16 consecutive wr_en starting 2 cycles after start.
   - zero_buffering low only on write indices 5,6,9,10, which carry data from addresses 0x10,0x11,0x12,0x13.
   - ex_window_done exactly one cycle after the last wr_en.
2. Same setup with num_groups=2 and depth_window_done returned 5 cycles after END:
   - Second group's first wr_en comes 2 cycles after that depth_window_done.
   - Second group reads addresses 0x14..0x17.
   - done pulses once, after the second handshake.
3. depth_window_done pulsed during FLUSH:
   - win_seen latches it.
   - WAIT lasts exactly one cycle.
   - No deadlock; done asserted.
4. rst=0 for one edge mid-STREAM:
   - All outputs 0 after that edge.
   - A new start produces a clean stream from the new base_addr.
5. start repeated while busy: ignored, with no stream restart. num_groups=0: done pulses 1 cycle after start, with zero wr_en and zero mem_rd_en.
6. base=0xFFFE, row_size=2: read addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001 (modulo wrap).
